physical_gearbox_align_ctrl: RTL

Sequencing controller for the receive 6:10 IOB gearbox. It holds the gearbox in reset and then releases it. It then sweeps the gearbox bitslip setting (0..9) against a known training word until word alignment is found, and reports lock or failure to the link layer. It runs in the write-side (serdes) clock domain. The aligned 10-bit gearbox word arrives already transferred into this domain by the existing CDC word handshake, qualified by a valid strobe.

---
 rtl/physical_gearbox_align_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/physical_gearbox_align_ctrl.sv
// Receive 6:10 gearbox alignment controller: gearbox reset, bitslip sweep, lock/fail report.
// Define PHYSICAL_ALIGN_CTRL_STATS_EN to add the o_slip_cnt / o_lock_cnt statistics outputs.
module physical_gearbox_align_ctrl #(
  parameter logic [9:0]  TRAIN_PATTERN = 10'h3E0,
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned SETTLE_CYCLES = 32,
  parameter int unsigned SLIP_WAIT     = 4,
  parameter int unsigned MATCH_CNT     = 8,
  parameter int unsigned MAX_SWEEPS    = 3
) (
  input  logic        i_wr_clk,
  input  logic        local_wr_arst_n,
  input  logic        i_start,
  input  logic        i_retrain,
  input  logic        i_word_vld,
  input  logic [9:0]  i_word,
  output logic        o_gb_arst_n,
  output logic [3:0]  o_slipbits,
  output logic        o_locked,
  output logic        o_fail,
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
  output logic [15:0] o_slip_cnt,
  output logic [7:0]  o_lock_cnt,
`endif
  output logic        o_busy
);

  localparam int unsigned RstW    = $clog2(RST_CYCLES + 1);
  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned DiscW   = $clog2(SLIP_WAIT + 1);
  localparam int unsigned MatchW  = $clog2(MATCH_CNT + 1);
  localparam int unsigned SweepW  = $clog2(MAX_SWEEPS + 1);

  typedef enum logic [2:0] {
    StIdle,
    StGbRst,
    StSettle,
    StSlip,
    StSearch,
    StLocked,
    StFail
  } state_e;

  state_e              r_state;
  logic                r_gb_arst_n;
  logic [3:0]          r_slipbits;
  logic                r_locked;
  logic                r_fail;
  logic                r_busy;
  logic [RstW-1:0]     r_rst_cnt;
  logic [SettleW-1:0]  r_settle_cnt;
  logic [DiscW-1:0]    r_disc_cnt;
  logic [MatchW-1:0]   r_match_cnt;
  logic [SweepW-1:0]   r_sweep_cnt;

  logic                w_req;
  logic                w_restart;
  logic                w_match;

  assign w_req   = i_start | i_retrain;
  assign w_match = (i_word == TRAIN_PATTERN);
  // LOCKED only yields to retrain; GB_RST ignores all requests and runs to completion.
  assign w_restart = (r_state == StLocked) ? i_retrain : (w_req && (r_state != StGbRst));

`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
  logic [15:0] r_slip_cnt;
  logic [7:0]  r_lock_cnt;
  logic [15:0] w_slip_cnt_inc;
  logic [7:0]  w_lock_cnt_inc;

  assign w_slip_cnt_inc = (r_slip_cnt == 16'hFFFF) ? r_slip_cnt : r_slip_cnt + 16'd1;
  assign w_lock_cnt_inc = (r_lock_cnt == 8'hFF) ? r_lock_cnt : r_lock_cnt + 8'd1;
  assign o_slip_cnt     = r_slip_cnt;
  assign o_lock_cnt     = r_lock_cnt;
`endif

  always_ff @(posedge i_wr_clk or negedge local_wr_arst_n) begin
    if (!local_wr_arst_n) begin
      r_state      <= StIdle;
      r_gb_arst_n  <= 1'b0;
      r_slipbits   <= 4'd0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_busy       <= 1'b0;
      r_rst_cnt    <= '0;
      r_settle_cnt <= '0;
      r_disc_cnt   <= '0;
      r_match_cnt  <= '0;
      r_sweep_cnt  <= '0;
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
      r_slip_cnt   <= 16'd0;
      r_lock_cnt   <= 8'd0;
`endif
    end else if (w_restart) begin
      r_state     <= StGbRst;
      r_gb_arst_n <= 1'b0;
      r_slipbits  <= 4'd0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b1;
      r_rst_cnt   <= '0;
      r_sweep_cnt <= '0;
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
      r_slip_cnt  <= 16'd0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          r_gb_arst_n <= 1'b0;
        end
        StGbRst: begin
          if (r_rst_cnt == RstW'(RST_CYCLES - 1)) begin
            r_state      <= StSettle;
            r_gb_arst_n  <= 1'b1;
            r_settle_cnt <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RstW'(1);
          end
        end
        StSettle: begin
          if (r_settle_cnt == SettleW'(SETTLE_CYCLES - 1)) begin
            r_state    <= StSlip;
            r_disc_cnt <= DiscW'(SLIP_WAIT);
          end else begin
            r_settle_cnt <= r_settle_cnt + SettleW'(1);
          end
        end
        StSlip: begin
          if (i_word_vld) begin
            r_disc_cnt <= r_disc_cnt - DiscW'(1);
            if (r_disc_cnt == DiscW'(1)) begin
              r_state     <= StSearch;
              r_match_cnt <= '0;
            end
          end
        end
        StSearch: begin
          if (i_word_vld) begin
            if (w_match) begin
              if (r_match_cnt == MatchW'(MATCH_CNT - 1)) begin
                r_state  <= StLocked;
                r_locked <= 1'b1;
                r_busy   <= 1'b0;
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
                r_lock_cnt <= w_lock_cnt_inc;
`endif
              end else begin
                r_match_cnt <= r_match_cnt + MatchW'(1);
              end
            end else if (r_slipbits == 4'd9) begin
              // Last sweep exhausted: keep slip at 9 so the failing setting stays visible.
              if (r_sweep_cnt == SweepW'(MAX_SWEEPS - 1)) begin
                r_state <= StFail;
                r_fail  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state     <= StSlip;
                r_slipbits  <= 4'd0;
                r_sweep_cnt <= r_sweep_cnt + SweepW'(1);
                r_disc_cnt  <= DiscW'(SLIP_WAIT);
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
                r_slip_cnt  <= w_slip_cnt_inc;
`endif
              end
            end else begin
              r_state    <= StSlip;
              r_slipbits <= r_slipbits + 4'd1;
              r_disc_cnt <= DiscW'(SLIP_WAIT);
`ifdef PHYSICAL_ALIGN_CTRL_STATS_EN
              r_slip_cnt <= w_slip_cnt_inc;
`endif
            end
          end
        end
        StLocked, StFail: begin
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_gb_arst_n = r_gb_arst_n;
  assign o_slipbits  = r_slipbits;
  assign o_locked    = r_locked;
  assign o_fail      = r_fail;
  assign o_busy      = r_busy;

endmodule
